// File: rtl/atm_session_if.sv
// Bundle of every user-side, core-side and status signal of the ATM session
// controller. The controller sits on the slave side. The master side drives the
// card, keypad and core-completion inputs.
interface atm_session_if;
    // user / card side
    logic        card_in;
    logic [3:0]  card_acc;
    logic        pin_valid;
    logic [15:0] pin_in;
    logic        op_valid;
    logic [2:0]  op_sel;
    logic [15:0] amount_in;
    logic [15:0] newpin_in;
    logic        logout;
    // ATM core side
    logic        atm_start;
    logic [2:0]  atm_operation;
    logic [3:0]  atm_acc_num;
    logic [15:0] atm_pin;
    logic [15:0] atm_amount;
    logic [15:0] atm_newpin;
    logic        atm_done;
    logic        atm_success;
    // status
    logic        session_active;
    logic        card_eject;
    logic        card_retained;
    logic        result_ok;
    logic        result_err;
    logic [1:0]  tries_left;
    logic [2:0]  state;

    modport slave (
        input  card_in, card_acc, pin_valid, pin_in, op_valid, op_sel,
               amount_in, newpin_in, logout, atm_done, atm_success,
        output atm_start, atm_operation, atm_acc_num, atm_pin, atm_amount,
               atm_newpin, session_active, card_eject, card_retained,
               result_ok, result_err, tries_left, state
    );

    modport master (
        output card_in, card_acc, pin_valid, pin_in, op_valid, op_sel,
               amount_in, newpin_in, logout, atm_done, atm_success,
        input  atm_start, atm_operation, atm_acc_num, atm_pin, atm_amount,
               atm_newpin, session_active, card_eject, card_retained,
               result_ok, result_err, tries_left, state
    );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card insertion, PIN verification with retry lockout,
// operation dispatch to the ATM core, and inactivity and core timeouts.
module atm_session_ctrl #(
    parameter int MAX_TRIES    = 3,
    parameter int IDLE_TIMEOUT = 1000,
    parameter int CORE_TIMEOUT = 64
) (
    input logic         clk,
    input logic         rst_n,
    atm_session_if.slave bus
);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int CW = $clog2(CORE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_WAIT_PIN = 3'd1, S_CHECK_PIN = 3'd2, S_MENU = 3'd3,
        S_EXEC = 3'd4, S_RESULT = 3'd5, S_EJECT = 3'd6, S_LOCKED = 3'd7
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      tries_q;
    logic [3:0]      acc_q;
    logic [2:0]      op_q;
    logic [15:0]     pin_q, amt_q, newpin_q;
    logic [IW-1:0]   idle_cnt_q;
    logic [CW-1:0]   core_cnt_q;
    logic            card_gone_q;
    logic            start_q, ok_q, err_q;
    logic            start_d, ok_d, err_d;
    logic            sess, eject, retained;

    // The cycle that raises atm_start cannot also see that transaction's done.
    logic in_core, done_v, core_to, idle_to, gone, op_ok, activity;
    assign in_core  = (state_q == S_CHECK_PIN) || (state_q == S_EXEC);
    assign done_v   = in_core && bus.atm_done && !start_q;
    assign core_to  = in_core && (core_cnt_q == CW'(CORE_TIMEOUT)) && !done_v;
    assign idle_to  = (idle_cnt_q == IW'(IDLE_TIMEOUT));
    assign gone     = card_gone_q || !bus.card_in;
    assign op_ok    = (bus.op_sel != 3'd0) && (bus.op_sel != 3'd7);
    assign activity = bus.pin_valid || bus.op_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic. A card pulled mid-transaction is only acted on
    // once the core finishes or times out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (bus.card_in) state_d = S_WAIT_PIN;
            S_WAIT_PIN: begin
                if (!bus.card_in)       state_d = S_IDLE;
                else if (bus.pin_valid) state_d = S_CHECK_PIN;
                else if (idle_to)       state_d = S_EJECT;
            end
            S_CHECK_PIN: begin
                if (done_v) begin
                    if (gone)                 state_d = S_IDLE;
                    else if (bus.atm_success) state_d = S_MENU;
                    else if (tries_q <= 2'd1) state_d = S_LOCKED;
                    else                      state_d = S_WAIT_PIN;
                end else if (core_to) begin
                    state_d = gone ? S_IDLE : S_EJECT;
                end
            end
            S_MENU: begin
                if (!bus.card_in)                state_d = S_IDLE;
                else if (bus.logout)             state_d = S_EJECT;
                else if (bus.op_valid && op_ok)  state_d = S_EXEC;
                else if (!bus.op_valid && idle_to) state_d = S_EJECT;
            end
            S_EXEC: begin
                if (done_v)       state_d = gone ? S_IDLE : S_RESULT;
                else if (core_to) state_d = gone ? S_IDLE : S_EJECT;
            end
            S_RESULT:    state_d = S_MENU;
            S_EJECT,
            S_LOCKED:    if (!bus.card_in) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output logic: state-decoded levels plus next values of the registered pulses
    always_comb begin
        start_d  = ((state_d == S_CHECK_PIN) || (state_d == S_EXEC)) && (state_d != state_q);
        ok_d     = (state_d == S_RESULT) && bus.atm_success;
        err_d    = ((state_d == S_RESULT) && !bus.atm_success)
                 || ((state_q == S_MENU) && bus.card_in && !bus.logout && bus.op_valid && !op_ok)
                 || core_to;
        sess     = (state_q == S_MENU) || (state_q == S_EXEC) || (state_q == S_RESULT);
        eject    = (state_q == S_EJECT);
        retained = (state_q == S_LOCKED);
    end

    // Operand latches, try counter, timers and registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tries_q     <= '0;
            acc_q       <= '0;
            op_q        <= '0;
            pin_q       <= '0;
            amt_q       <= '0;
            newpin_q    <= '0;
            idle_cnt_q  <= '0;
            core_cnt_q  <= '0;
            card_gone_q <= 1'b0;
            start_q     <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            start_q <= start_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            if (state_q == S_IDLE && bus.card_in) begin
                acc_q   <= bus.card_acc;
                tries_q <= 2'(MAX_TRIES);
            end
            if (state_q == S_WAIT_PIN && bus.card_in && bus.pin_valid) begin
                pin_q <= bus.pin_in;
                op_q  <= 3'd0;
            end
            if (state_q == S_CHECK_PIN && done_v && !bus.atm_success && tries_q != 2'd0)
                tries_q <= tries_q - 2'd1;
            if (state_q == S_MENU && state_d == S_EXEC) begin
                op_q     <= bus.op_sel;
                amt_q    <= bus.amount_in;
                newpin_q <= bus.newpin_in;
            end
            if (state_q == S_EXEC && done_v && bus.atm_success && op_q == 3'd5)
                pin_q <= newpin_q;
            if (state_d != state_q || activity)
                idle_cnt_q <= '0;
            else if ((state_q == S_WAIT_PIN || state_q == S_MENU) && !idle_to)
                idle_cnt_q <= idle_cnt_q + 1'b1;
            if (start_d)
                core_cnt_q <= '0;
            else if (in_core && core_cnt_q != CW'(CORE_TIMEOUT))
                core_cnt_q <= core_cnt_q + 1'b1;
            card_gone_q <= in_core ? (card_gone_q || !bus.card_in) : 1'b0;
        end
    end

    assign bus.atm_start      = start_q;
    assign bus.atm_operation  = op_q;
    assign bus.atm_acc_num    = acc_q;
    assign bus.atm_pin        = pin_q;
    assign bus.atm_amount     = amt_q;
    assign bus.atm_newpin     = newpin_q;
    assign bus.session_active = sess;
    assign bus.card_eject     = eject;
    assign bus.card_retained  = retained;
    assign bus.result_ok      = ok_q;
    assign bus.result_err     = err_q;
    assign bus.tries_left     = tries_q;
    assign bus.state          = state_q;
endmodule
